// File: rtl/cv32e40x_div_seq.sv
// cv32e40x_div_seq: iterative DIV/DIVU/REM/REMU sequencer borrowing the ALU CLZ and shifter
module cv32e40x_div_seq #(
  parameter bit ZERO_DVD_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kill_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        alu_sel_o,
  output logic [31:0] alu_op_a_o,
  output logic        alu_clz_en_o,
  output logic [31:0] alu_clz_data_o,
  input  logic [5:0]  alu_clz_res_i,
  output logic        alu_shift_en_o,
  output logic [5:0]  alu_shift_amt_o,
  input  logic [31:0] alu_shifted_i
);
  typedef enum logic [2:0] {IDLE, CLZ, SHIFT, DIV, DONE} state_t;
  state_t state, state_n;
  logic [1:0]  op;
  logic        neg_a, neg_b;
  logic [31:0] abs_b, q, result;
  logic [32:0] rem, dsr;
  logic [5:0]  clz, cnt;
  logic        a_neg_i, b_neg_i, b_zero, ovf, a_zero, special, accept;
  logic [31:0] abs_a_i, abs_b_i, special_res;
  logic [32:0] dsr_cur, rem_nx;
  logic [31:0] q_nx, q_fix, rem_fix, fin;
  logic        ge, last;
  assign a_neg_i     = ~op_i[0] & op_a_i[31];
  assign b_neg_i     = ~op_i[0] & op_b_i[31];
  assign abs_a_i     = a_neg_i ? -op_a_i : op_a_i;
  assign abs_b_i     = b_neg_i ? -op_b_i : op_b_i;
  assign b_zero      = op_b_i == 32'd0;
  assign ovf         = ~op_i[0] & (op_a_i == 32'h8000_0000) & (op_b_i == 32'hFFFF_FFFF);
  assign a_zero      = ZERO_DVD_BYPASS && (op_a_i == 32'd0);
  assign special     = b_zero | ovf | a_zero;
  assign special_res = b_zero ? (op_i[1] ? op_a_i : 32'hFFFF_FFFF) :
                       ovf    ? (op_i[1] ? 32'd0 : 32'h8000_0000) : 32'd0;
  assign accept      = (state == IDLE) & valid_i & ~kill_i;
  // SHIFT already runs the first iteration on the freshly shifted divisor from the ALU
  assign dsr_cur = (state == SHIFT) ? {1'b0, alu_shifted_i} : dsr;
  assign ge      = rem >= dsr_cur;
  assign rem_nx  = ge ? rem - dsr_cur : rem;
  assign q_nx    = {q[30:0], ge};
  assign last    = cnt == clz;
  assign q_fix   = (~op[0] & (neg_a ^ neg_b)) ? -q_nx : q_nx;
  assign rem_fix = (~op[0] & neg_a) ? -rem_nx[31:0] : rem_nx[31:0];
  assign fin     = op[1] ? rem_fix : q_fix;
  assign ready_o         = state == IDLE;
  assign valid_o         = state == DONE;
  assign result_o        = result;
  assign alu_clz_en_o    = state == CLZ;
  assign alu_clz_data_o  = (state == CLZ) ? abs_b : 32'd0;
  assign alu_shift_en_o  = state == SHIFT;
  assign alu_sel_o       = state == SHIFT;
  assign alu_op_a_o      = (state == SHIFT) ? abs_b : 32'd0;
  assign alu_shift_amt_o = (state == SHIFT) ? clz : 6'd0;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       state_n = valid_i ? (special ? DONE : CLZ) : IDLE;
      CLZ:        state_n = SHIFT;
      SHIFT, DIV: state_n = last ? DONE : DIV;
      DONE:       state_n = ready_i ? IDLE : DONE;
      default:    state_n = IDLE;
    endcase
    if (kill_i) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op     <= 2'd0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      abs_b  <= 32'd0;
      q      <= 32'd0;
      rem    <= 33'd0;
      dsr    <= 33'd0;
      clz    <= 6'd0;
      cnt    <= 6'd0;
      result <= 32'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        op    <= op_i;
        neg_a <= a_neg_i;
        neg_b <= b_neg_i;
        abs_b <= abs_b_i;
        rem   <= {1'b0, abs_a_i};
        q     <= 32'd0;
        cnt   <= 6'd0;
        if (special) result <= special_res;
      end
      if (state == CLZ) clz <= alu_clz_res_i;
      if (state == SHIFT || state == DIV) begin
        rem <= rem_nx;
        q   <= q_nx;
        dsr <= dsr_cur >> 1;
        cnt <= cnt + 6'd1;
        if (last && !kill_i) result <= fin;
      end
    end
  end
endmodule
